// File: rtl/bias_buffer_pkg.sv
// Shared types and constants for the bias buffer: FSM states, config word
// layout and the beat format carried through the output skid FIFO.
package bias_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SERVE = 2'd2
    } state_e;

    localparam int LEN_LSB = 0;
    localparam int REP_LSB = 16;
    localparam int CFG_W   = 16;
    localparam int LANE_W  = 32;
    localparam int LANES   = 4;
    localparam int BEAT_W  = LANE_W * LANES;

    typedef struct packed {
        logic              last;
        logic [BEAT_W-1:0] data;
    } beat_t;

    function automatic logic [CFG_W-1:0] cfg_field(input logic [31:0] word, input int lsb);
        return word[lsb +: CFG_W];
    endfunction

endpackage

// File: rtl/bias_buffer_if.sv
// Stream bundle around the bias buffer: config and bias inputs, replayed bias
// output and the two status signals. 'slave' is the buffer's view.
interface bias_buffer_if;
    import bias_buffer_pkg::*;

    logic                 s_axis_bcfg_tvalid;
    logic                 s_axis_bcfg_tready;
    logic [LANE_W-1:0]    s_axis_bcfg_tdata;
    logic                 s_axis_bias_tvalid;
    logic                 s_axis_bias_tready;
    logic [BEAT_W-1:0]    s_axis_bias_tdata;
    logic                 m_axis_bias_tvalid;
    logic                 m_axis_bias_tready;
    logic [BEAT_W-1:0]    m_axis_bias_tdata;
    logic                 m_axis_bias_tlast;
    logic                 cfg_err;
    logic [1:0]           status_bb;

    modport master (
        output s_axis_bcfg_tvalid, s_axis_bcfg_tdata,
        input  s_axis_bcfg_tready,
        output s_axis_bias_tvalid, s_axis_bias_tdata,
        input  s_axis_bias_tready,
        input  m_axis_bias_tvalid, m_axis_bias_tdata, m_axis_bias_tlast,
        output m_axis_bias_tready,
        input  cfg_err, status_bb
    );

    modport slave (
        input  s_axis_bcfg_tvalid, s_axis_bcfg_tdata,
        output s_axis_bcfg_tready,
        input  s_axis_bias_tvalid, s_axis_bias_tdata,
        output s_axis_bias_tready,
        output m_axis_bias_tvalid, m_axis_bias_tdata, m_axis_bias_tlast,
        input  m_axis_bias_tready,
        output cfg_err, status_bb
    );

endinterface

// File: rtl/bias_ram_sdp.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
// A read of the address being written in the same cycle returns the new data.
module bias_ram_sdp #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // NOTE: no reset on the array or read register; a reset would stop BRAM inference.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bias_buffer.sv
// Captures one layer's bias stream into RAM, then replays it 'rep' times
// through a 2-entry skid FIFO with tlast on the final beat of every pass.
module bias_buffer
    import bias_buffer_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input logic          clk,
    input logic          rst,
    bias_buffer_if.slave bus
);

    state_e            state_q;
    logic [CFG_W-1:0]  len_q;
    logic [CFG_W-1:0]  rep_q;
    logic [CFG_W-1:0]  pass_cnt_q;
    logic [CFG_W-1:0]  out_pass_q;
    logic [AW:0]       wr_ptr_q;
    logic [AW:0]       rd_ptr_q;
    logic              rd_done_q;
    logic              cfg_err_q;
    logic              rd_pend_q;
    logic              rd_pend_last_q;
    beat_t             slot0_q;
    logic              slot1_last_q;
    logic [BEAT_W-1:0] slot1_data_q;
    logic [1:0]        cnt_q;

    logic [CFG_W-1:0]  cfg_len;
    logic [CFG_W-1:0]  cfg_rep;
    logic              cfg_bad;
    logic              cfg_hs;
    logic              bias_hs;
    logic              out_hs;
    logic              wr_last;
    logic              rd_last;
    logic              out_final;
    logic              rd_en;
    logic [1:0]        level;
    logic [1:0]        wr_slot;
    logic [BEAT_W-1:0] ram_rdata;

    assign cfg_len   = cfg_field(bus.s_axis_bcfg_tdata, LEN_LSB);
    assign cfg_rep   = cfg_field(bus.s_axis_bcfg_tdata, REP_LSB);
    assign cfg_bad   = (cfg_len == '0) || (32'(cfg_len) > 32'(DEPTH));
    assign cfg_hs    = bus.s_axis_bcfg_tvalid && (state_q == IDLE);
    assign bias_hs   = bus.s_axis_bias_tvalid && (state_q == LOAD);
    assign out_hs    = (cnt_q != 2'd0) && bus.m_axis_bias_tready;
    assign wr_last   = (16'(wr_ptr_q) + 16'd1) == len_q;
    assign rd_last   = (16'(rd_ptr_q) + 16'd1) == len_q;
    assign out_final = out_hs && slot0_q.last && (out_pass_q == rep_q - 16'd1);
    assign wr_slot   = cnt_q - 2'(out_hs);

    // The first read is issued alongside the final load beat to reach the 2-cycle latency.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        level = cnt_q - 2'(out_hs) + 2'(rd_pend_q);
        rd_en = 1'b0;
        if (bias_hs && wr_last) begin
            rd_en = 1'b1;
        end else if ((state_q == SERVE) && !rd_done_q && (level < 2'd2)) begin
            rd_en = 1'b1;
        end
    end

    bias_ram_sdp #(
        .WIDTH (BEAT_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (bias_hs),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (bus.s_axis_bias_tdata),
        .re_i    (rd_en),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            rep_q      <= '0;
            pass_cnt_q <= '0;
            out_pass_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_done_q  <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            if (rd_en) begin
                if (rd_last) begin
                    rd_ptr_q   <= '0;
                    pass_cnt_q <= pass_cnt_q + 16'd1;
                    if (pass_cnt_q == rep_q - 16'd1) begin
                        rd_done_q <= 1'b1;
                    end
                end else begin
                    rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
                end
            end
            if (out_hs && slot0_q.last) begin
                out_pass_q <= out_pass_q + 16'd1;
            end

            case (state_q)
                IDLE: begin
                    if (cfg_hs) begin
                        if (cfg_bad) begin
                            cfg_err_q <= 1'b1;
                        end else begin
                            len_q   <= cfg_len;
                            rep_q   <= (cfg_rep == '0) ? 16'd1 : cfg_rep;
                            state_q <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (bias_hs) begin
                        if (wr_last) begin
                            wr_ptr_q <= '0;
                            state_q  <= SERVE;
                        end else begin
                            wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
                        end
                    end
                end
                SERVE: begin
                    if (out_final) begin
                        state_q    <= IDLE;
                        rd_ptr_q   <= '0;
                        pass_cnt_q <= '0;
                        out_pass_q <= '0;
                        rd_done_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Issue throttling guarantees the FIFO always has room for a returning read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_q      <= 1'b0;
            rd_pend_last_q <= 1'b0;
            cnt_q          <= '0;
            slot0_q        <= '0;
            slot1_last_q   <= 1'b0;
            slot1_data_q   <= '0;
        end else begin
            rd_pend_q      <= rd_en;
            rd_pend_last_q <= rd_last;
            cnt_q          <= level;
            if (out_hs) begin
                slot0_q <= '{last: slot1_last_q, data: slot1_data_q};
            end
            if (rd_pend_q) begin
                if (wr_slot == 2'd0) begin
                    slot0_q <= '{last: rd_pend_last_q, data: ram_rdata};
                end else begin
                    slot1_last_q <= rd_pend_last_q;
                    slot1_data_q <= ram_rdata;
                end
            end
        end
    end

    assign bus.s_axis_bcfg_tready = (state_q == IDLE);
    assign bus.s_axis_bias_tready = (state_q == LOAD);
    assign bus.m_axis_bias_tvalid = (cnt_q != 2'd0);
    assign bus.m_axis_bias_tdata  = slot0_q.data;
    assign bus.m_axis_bias_tlast  = slot0_q.last;
    assign bus.cfg_err            = cfg_err_q;
    assign bus.status_bb          = state_q;

endmodule

// File: tb/tb_bias_buffer.sv
// Directed bench for bias_buffer: loads known beat sets, replays them under
// constant and random backpressure, and covers bad config and mid-run reset.
module tb_bias_buffer;
    import bias_buffer_pkg::*;

    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bias_buffer_if bus ();

    bias_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [BEAT_W-1:0] stim [DEPTH];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BEAT_W-1:0] make_beat(input int tid, input int k);
        return {8'(tid), 8'd3, 16'(k + 1), 8'(tid), 8'd2, 16'(k + 1),
                8'(tid), 8'd1, 16'(k + 1), 8'(tid), 8'd0, 16'(k + 1)};
    endfunction

    task automatic fill(input int tid, input int len);
        for (int k = 0; k < len; k++) stim[k] = make_beat(tid, k);
    endtask

    task automatic send_cfg(input int len, input int rep);
        int waited = 0;
        bus.s_axis_bcfg_tdata  = {16'(rep), 16'(len)};
        bus.s_axis_bcfg_tvalid = 1'b1;
        while (!bus.s_axis_bcfg_tready && waited < 50) begin
            tick();
            waited++;
        end
        check("cfg_accept_wait", 128'(waited < 50), 128'd1);
        tick();
        bus.s_axis_bcfg_tvalid = 1'b0;
    endtask

    task automatic load(input int len);
        int timeouts = 0;
        for (int k = 0; k < len; k++) begin
            int waited = 0;
            bus.s_axis_bias_tvalid = 1'b1;
            bus.s_axis_bias_tdata  = stim[k];
            while (!bus.s_axis_bias_tready && waited < 50) begin
                tick();
                waited++;
            end
            if (waited >= 50) timeouts++;
            tick();
        end
        bus.s_axis_bias_tvalid = 1'b0;
        check("load_ready_timeouts", 128'(timeouts), 128'd0);
    endtask

    // Consumes up to stop_after beats; called the cycle after the final load beat.
    task automatic run_serve(input string name, input int len, input int reps,
                             input int duty, input int stop_after);
        int idx = 0;
        int cyc = 0;
        int first_v = -1;
        int first_hs = -1;
        int last_hs = -1;
        logic held_v = 1'b0;
        logic held_l = 1'b0;
        logic [BEAT_W-1:0] held_d = '0;
        while (idx < stop_after && cyc < 3000) begin
            bus.m_axis_bias_tready = ($urandom_range(0, 99) < duty);
            if (held_v) begin
                check({name, ":stall_valid"}, 128'(bus.m_axis_bias_tvalid), 128'd1);
                check({name, ":stall_data"}, bus.m_axis_bias_tdata, held_d);
                check({name, ":stall_last"}, 128'(bus.m_axis_bias_tlast), 128'(held_l));
            end
            if (bus.m_axis_bias_tvalid && first_v < 0) first_v = cyc;
            if (bus.m_axis_bias_tvalid) begin
                if (bus.m_axis_bias_tready) begin
                    check({name, ":data"}, bus.m_axis_bias_tdata, stim[idx % len]);
                    check({name, ":last"}, 128'(bus.m_axis_bias_tlast),
                          128'((idx % len) == len - 1));
                    if (first_hs < 0) first_hs = cyc;
                    last_hs = cyc;
                    idx++;
                    held_v = 1'b0;
                end else begin
                    held_v = 1'b1;
                    held_d = bus.m_axis_bias_tdata;
                    held_l = bus.m_axis_bias_tlast;
                end
            end
            tick();
            cyc++;
        end
        bus.m_axis_bias_tready = 1'b0;
        check({name, ":beat_count"}, 128'(idx), 128'(stop_after));
        check({name, ":latency"}, 128'(first_v), 128'd1);
        if (duty >= 100) check({name, ":gapless"}, 128'(last_hs - first_hs), 128'(stop_after - 1));
        if (stop_after == len * reps) begin
            check({name, ":end_state"}, 128'(bus.status_bb), 128'd0);
            check({name, ":end_valid"}, 128'(bus.m_axis_bias_tvalid), 128'd0);
            check({name, ":end_cfg_ready"}, 128'(bus.s_axis_bcfg_tready), 128'd1);
        end
    endtask

    initial begin
        bus.s_axis_bcfg_tvalid = 1'b0;
        bus.s_axis_bcfg_tdata  = '0;
        bus.s_axis_bias_tvalid = 1'b0;
        bus.s_axis_bias_tdata  = '0;
        bus.m_axis_bias_tready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        check("rst:state", 128'(bus.status_bb), 128'd0);
        check("rst:cfg_ready", 128'(bus.s_axis_bcfg_tready), 128'd1);
        check("rst:bias_ready", 128'(bus.s_axis_bias_tready), 128'd0);
        check("rst:m_valid", 128'(bus.m_axis_bias_tvalid), 128'd0);
        check("rst:m_data", bus.m_axis_bias_tdata, 128'd0);
        check("rst:m_last", 128'(bus.m_axis_bias_tlast), 128'd0);
        check("rst:cfg_err", 128'(bus.cfg_err), 128'd0);

        fill(1, 4);
        send_cfg(4, 3);
        check("basic:load_state", 128'(bus.status_bb), 128'd1);
        check("basic:load_cfg_ready", 128'(bus.s_axis_bcfg_tready), 128'd0);
        load(4);
        check("basic:serve_bias_ready", 128'(bus.s_axis_bias_tready), 128'd0);
        run_serve("basic", 4, 3, 100, 12);

        fill(2, 4);
        send_cfg(4, 3);
        load(4);
        run_serve("bp", 4, 3, 30, 12);

        fill(3, 1);
        send_cfg(1, 5);
        load(1);
        run_serve("len1", 1, 5, 100, 5);

        fill(4, 256);
        send_cfg(256, 1);
        load(256);
        run_serve("full", 256, 1, 100, 256);

        fill(5, 3);
        bus.s_axis_bias_tdata  = stim[0];
        bus.s_axis_bias_tvalid = 1'b1;
        check("same_cycle:bias_ready", 128'(bus.s_axis_bias_tready), 128'd0);
        send_cfg(3, 0);
        load(3);
        run_serve("rep0", 3, 1, 100, 3);

        send_cfg(0, 1);
        check("bad0:cfg_err", 128'(bus.cfg_err), 128'd1);
        check("bad0:state", 128'(bus.status_bb), 128'd0);
        check("bad0:bias_ready", 128'(bus.s_axis_bias_tready), 128'd0);
        send_cfg(257, 1);
        check("bad257:cfg_err", 128'(bus.cfg_err), 128'd1);
        check("bad257:state", 128'(bus.status_bb), 128'd0);
        check("bad257:bias_ready", 128'(bus.s_axis_bias_tready), 128'd0);
        fill(6, 2);
        send_cfg(2, 2);
        check("after_bad:state", 128'(bus.status_bb), 128'd1);
        load(2);
        run_serve("after_bad", 2, 2, 100, 4);
        check("after_bad:cfg_err_sticky", 128'(bus.cfg_err), 128'd1);

        fill(7, 4);
        send_cfg(4, 3);
        load(4);
        run_serve("midrst", 4, 3, 100, 6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst:state", 128'(bus.status_bb), 128'd0);
        check("midrst:m_valid", 128'(bus.m_axis_bias_tvalid), 128'd0);
        check("midrst:cfg_ready", 128'(bus.s_axis_bcfg_tready), 128'd1);
        check("midrst:cfg_err", 128'(bus.cfg_err), 128'd0);
        fill(8, 3);
        send_cfg(3, 2);
        load(3);
        run_serve("post_rst", 3, 2, 30, 6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end of the sequence");
        $fatal(1);
    end

endmodule
